pulse_param_sequencer: RTL and testbench
========================================

Name: pulse_param_sequencer

Overview:
- Upstream stage for the pulse counter. Holds a table of per-pulse parameter sets (DR, PW, DF, PRI) and presents the current set to the counter as PRI, DR, DR_PW and PW_COVER.
- Steps through the table one entry per pulse repetition interval, producing staggered or agile PRI pulse trains.
- Keeps its own shadow period counter that mirrors the downstream counter, so parameters change exactly on the counter's wrap edge.
- Drives the downstream counter's reset, so both start in lockstep.

Parameters:
DEPTH, 16, number of table entries
AW, 4, table address width (clog2 of DEPTH)

Ports:
clk_in  in  1  clock
nreset  in  1  synchronous active-low reset
run  in  1  1 = sequence active; 0 = idle, downstream held in reset
cfg_wr_en  in  1  table write strobe, one entry per cycle
cfg_addr  in  AW  table write address
cfg_dr  in  32  delay to pulse rise
cfg_pw  in  32  pulse width
cfg_df  in  32  cover extension after pulse end
cfg_pri  in  32  period terminal count; period length is PRI+1 cycles
cfg_len  in  AW+1  active entry count; 0 is treated as 1, values above DEPTH are clamped to DEPTH
pri_o  out  32  to counter PRI
dr_o  out  32  to counter DR
dr_pw_o  out  32  to counter DR_PW
pw_cover_o  out  32  to counter PW_COVER
ctr_nreset  out  1  to counter nreset
cur_idx  out  AW  index of the entry currently presented
period_strobe  out  1  1-cycle pulse on each period boundary
seq_wrap  out  1  1-cycle pulse when cur_idx wraps from len-1 to 0
done  out  1  burst complete (see Optional Feature)

Behaviour:
- Reset (nreset=0 at an edge):
  - Table cleared to 0.
  - All outputs 0, including ctr_nreset=0.
  - Shadow count, next_idx and stage register cleared to 0.
- Arithmetic:
  - dr_pw = DR+PW and pw_cover = DF+PW+DR, computed 34 bits wide and saturated to 0xFFFFFFFF.
  - Computed in the stage register, never combinationally on the outputs.
- Stage register:
  - Holds the precomputed {PRI, DR, dr_pw, pw_cover} of table[next_idx].
  - Non-boundary edge: stage <= table[next_idx].
  - Table is read before write: a write at the same edge is seen by stage one edge later.
- States:
  - IDLE: ctr_nreset=0, shadow count=0, next_idx=0.
  - On run=1: on the next edge load outputs from table[0] directly (computed), set cur_idx=0, next_idx=wrap(1), stage<=table[wrap(1)], set ctr_nreset=1, go to RUN.
- RUN:
  - Shadow count increments each cycle.
  - Boundary: shadow count >= pri_o.
  - At a boundary edge, all in one edge:
    - Shadow count <= 0, outputs <= stage.
    - cur_idx <= next_idx; next_idx <= wrap(next_idx+1); stage <= table[wrap(next_idx+1)].
    - period_strobe=1 for that cycle; seq_wrap=1 if the new cur_idx is 0.
  - wrap(i) = 0 when i >= len_eff, else i.
  - PRI=0 produces a boundary every cycle and must work (consecutive boundaries).
- run deasserted in RUN: next edge returns to IDLE, ctr_nreset=0, pri/dr/dr_pw/pw_cover outputs hold their last values, cur_idx=0.
- cfg_len changed mid-run: takes effect at the next wrap() evaluation. If next_idx >= new len, the sequence wraps to 0 at the next boundary.
- Table writes while running are allowed. A write reaches the outputs only via stage, at the first boundary edge at least one edge after the write.

Optional Feature:
- Macro SEQ_BURST_EN.
- Defined:
  - Adds input cfg_bursts[15:0], sampled on the IDLE->RUN transition.
  - Counts seq_wrap events. When the count reaches cfg_bursts (nonzero), at that same boundary edge: go to DONE, ctr_nreset=0, done=1.
  - done stays 1 until run=0 (then IDLE, done=0) or nreset.
  - cfg_bursts=0 means run forever.
- Undefined: no cfg_bursts port, done tied 0, runs until run=0.

Test Plan:
1. Table entry0 {DR=2,PW=3,DF=1,PRI=9}, entry1 {DR=1,PW=2,DF=0,PRI=5}, len=2; raise run -> first outputs pri=9, dr_pw=5, pw_cover=6, ctr_nreset=1; period_strobe 10 cycles later with outputs pri=5, dr_pw=3, pw_cover=3; next strobe 6 cycles later back to entry0 with seq_wrap=1; 16-cycle repeat.
2. Saturation: DR=0xFFFFFFF0, PW=0x20, DF=0x10 -> dr_pw_o=0xFFFFFFFF, pw_cover_o=0xFFFFFFFF.
3. PRI=0 in all 3 entries, len=3 -> period_strobe high every cycle, cur_idx 0,1,2,0; seq_wrap every 3rd cycle.
4. Write entry1 PRI=7 while entry0 (PRI=9) is active at shadow count 4 -> next boundary presents pri=7; write landing on the boundary edge itself -> old value presented.
5. run dropped at shadow count 3 -> next edge ctr_nreset=0, cur_idx=0; nreset pulse mid-run -> all outputs 0, table cleared.
6. SEQ_BURST_EN, cfg_bursts=2, len=2, PRI=3 -> done=1 and ctr_nreset=0 at the 4th boundary (16 cycles after start); run=0 -> done=0.

Source files
------------

// File: rtl/pulse_param_sequencer.sv
// Per-pulse parameter table sequencer for the pulse counter: presents one table entry per PRI period.
// Optional burst limit when SEQ_BURST_EN is defined (adds cfg_bursts, drives done).
module pulse_param_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_in,
  input  logic          nreset,
  input  logic          run,
  input  logic          cfg_wr_en,
  input  logic [AW-1:0] cfg_addr,
  input  logic [31:0]   cfg_dr,
  input  logic [31:0]   cfg_pw,
  input  logic [31:0]   cfg_df,
  input  logic [31:0]   cfg_pri,
  input  logic [AW:0]   cfg_len,
`ifdef SEQ_BURST_EN
  input  logic [15:0]   cfg_bursts,
`endif
  output logic [31:0]   pri_o,
  output logic [31:0]   dr_o,
  output logic [31:0]   dr_pw_o,
  output logic [31:0]   pw_cover_o,
  output logic          ctr_nreset,
  output logic [AW-1:0] cur_idx,
  output logic          period_strobe,
  output logic          seq_wrap,
  output logic          done
);

  typedef struct packed {
    logic [31:0] dr;
    logic [31:0] pw;
    logic [31:0] df;
    logic [31:0] pri;
  } entry_t;

  typedef struct packed {
    logic [31:0] pri;
    logic [31:0] dr;
    logic [31:0] dr_pw;
    logic [31:0] pw_cover;
  } params_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [31:0] sat32(input logic [33:0] v);
    return (|v[33:32]) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  function automatic params_t calc(input entry_t e);
    params_t p;
    p.pri      = e.pri;
    p.dr       = e.dr;
    p.dr_pw    = sat32({2'b00, e.dr} + {2'b00, e.pw});
    p.pw_cover = sat32({2'b00, e.df} + {2'b00, e.pw} + {2'b00, e.dr});
    return p;
  endfunction

  function automatic logic [AW-1:0] wrap_idx(input logic [AW:0] i, input logic [AW:0] len);
    return (i >= len) ? '0 : i[AW-1:0];
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [AW-1:0] next_idx_q, next_idx_d;
  logic [AW-1:0] cur_idx_q, cur_idx_d;
  params_t       stage_q, stage_d;
  params_t       out_q, out_d;
  logic          ctr_nreset_q, ctr_nreset_d;
  logic          strobe_q, strobe_d;
  logic          wrap_q, wrap_d;
  entry_t        table_q [DEPTH];
  entry_t        table_d [DEPTH];
`ifdef SEQ_BURST_EN
  logic          done_q, done_d;
  logic [15:0]   bursts_q, bursts_d;
  logic [15:0]   wraps_q, wraps_d;
`endif

  logic [AW:0]   len_eff;
  logic [AW-1:0] idx_hold, idx_adv, idx_first;

  always_comb begin
    if (cfg_len == '0)                     len_eff = (AW+1)'(1);
    else if (cfg_len > (AW+1)'(DEPTH))     len_eff = (AW+1)'(DEPTH);
    else                                   len_eff = cfg_len;
  end

  // Re-wrapping next_idx on quiet edges lets a shrunk cfg_len take effect before the next boundary.
  assign idx_hold  = wrap_idx({1'b0, next_idx_q}, len_eff);
  assign idx_adv   = wrap_idx({1'b0, next_idx_q} + (AW+1)'(1), len_eff);
  assign idx_first = wrap_idx((AW+1)'(1), len_eff);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    next_idx_d   = next_idx_q;
    cur_idx_d    = cur_idx_q;
    stage_d      = stage_q;
    out_d        = out_q;
    ctr_nreset_d = ctr_nreset_q;
    strobe_d     = 1'b0;
    wrap_d       = 1'b0;
`ifdef SEQ_BURST_EN
    done_d       = done_q;
    bursts_d     = bursts_q;
    wraps_d      = wraps_q;
`endif
    table_d = table_q;
    if (cfg_wr_en) table_d[cfg_addr] = {cfg_dr, cfg_pw, cfg_df, cfg_pri};

    case (state_q)
      S_IDLE: begin
        cnt_d        = '0;
        next_idx_d   = '0;
        ctr_nreset_d = 1'b0;
        stage_d      = calc(table_q[0]);
        if (run) begin
          out_d        = calc(table_q[0]);
          cur_idx_d    = '0;
          next_idx_d   = idx_first;
          stage_d      = calc(table_q[idx_first]);
          ctr_nreset_d = 1'b1;
          state_d      = S_RUN;
`ifdef SEQ_BURST_EN
          bursts_d     = cfg_bursts;
          wraps_d      = '0;
`endif
        end
      end
      S_RUN: begin
        if (!run) begin
          state_d      = S_IDLE;
          ctr_nreset_d = 1'b0;
          cur_idx_d    = '0;
          cnt_d        = '0;
          next_idx_d   = '0;
        end else if (cnt_q >= out_q.pri) begin
          cnt_d      = '0;
          out_d      = stage_q;
          cur_idx_d  = next_idx_q;
          next_idx_d = idx_adv;
          stage_d    = calc(table_q[idx_adv]);
          strobe_d   = 1'b1;
          wrap_d     = (next_idx_q == '0);
`ifdef SEQ_BURST_EN
          if (next_idx_q == '0) begin
            wraps_d = wraps_q + 16'd1;
            if (bursts_q != '0 && wraps_d == bursts_q) begin
              state_d      = S_DONE;
              ctr_nreset_d = 1'b0;
              done_d       = 1'b1;
            end
          end
`endif
        end else begin
          cnt_d      = cnt_q + 32'd1;
          next_idx_d = idx_hold;
          stage_d    = calc(table_q[idx_hold]);
        end
      end
      S_DONE: begin
        cnt_d        = '0;
        ctr_nreset_d = 1'b0;
        if (!run) begin
          state_d   = S_IDLE;
          cur_idx_d = '0;
`ifdef SEQ_BURST_EN
          done_d    = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!nreset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      next_idx_q   <= '0;
      cur_idx_q    <= '0;
      stage_q      <= '0;
      out_q        <= '0;
      ctr_nreset_q <= 1'b0;
      strobe_q     <= 1'b0;
      wrap_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
`ifdef SEQ_BURST_EN
      done_q       <= 1'b0;
      bursts_q     <= '0;
      wraps_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      next_idx_q   <= next_idx_d;
      cur_idx_q    <= cur_idx_d;
      stage_q      <= stage_d;
      out_q        <= out_d;
      ctr_nreset_q <= ctr_nreset_d;
      strobe_q     <= strobe_d;
      wrap_q       <= wrap_d;
      table_q      <= table_d;
`ifdef SEQ_BURST_EN
      done_q       <= done_d;
      bursts_q     <= bursts_d;
      wraps_q      <= wraps_d;
`endif
    end
  end

  assign pri_o         = out_q.pri;
  assign dr_o          = out_q.dr;
  assign dr_pw_o       = out_q.dr_pw;
  assign pw_cover_o    = out_q.pw_cover;
  assign ctr_nreset    = ctr_nreset_q;
  assign cur_idx       = cur_idx_q;
  assign period_strobe = strobe_q;
  assign seq_wrap      = wrap_q;
`ifdef SEQ_BURST_EN
  assign done          = done_q;
`else
  assign done          = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_param_sequencer.sv
// Self-checking bench for pulse_param_sequencer; the reference model expands the table into a per-cycle schedule.
module tb_pulse_param_sequencer;
  localparam int NC = 64;

  logic        clk_in = 1'b0;
  logic        nreset, run, cfg_wr_en;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_dr, cfg_pw, cfg_df, cfg_pri;
  logic [4:0]  cfg_len;
`ifdef SEQ_BURST_EN
  logic [15:0] cfg_bursts;
`endif
  logic [31:0] pri_o, dr_o, dr_pw_o, pw_cover_o;
  logic        ctr_nreset, period_strobe, seq_wrap, done;
  logic [3:0]  cur_idx;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_dr [16];
  logic [31:0] m_pw [16];
  logic [31:0] m_df [16];
  logic [31:0] m_pri[16];

  logic [31:0] e_pri [NC];
  logic [31:0] e_dr  [NC];
  logic [31:0] e_drpw[NC];
  logic [31:0] e_cov [NC];
  logic [3:0]  e_idx [NC];
  logic        e_stb [NC];
  logic        e_wrp [NC];

  always #5 clk_in = ~clk_in;

  pulse_param_sequencer dut (
    .clk_in(clk_in), .nreset(nreset), .run(run), .cfg_wr_en(cfg_wr_en),
    .cfg_addr(cfg_addr), .cfg_dr(cfg_dr), .cfg_pw(cfg_pw), .cfg_df(cfg_df),
    .cfg_pri(cfg_pri), .cfg_len(cfg_len),
`ifdef SEQ_BURST_EN
    .cfg_bursts(cfg_bursts),
`endif
    .pri_o(pri_o), .dr_o(dr_o), .dr_pw_o(dr_pw_o), .pw_cover_o(pw_cover_o),
    .ctr_nreset(ctr_nreset), .cur_idx(cur_idx), .period_strobe(period_strobe),
    .seq_wrap(seq_wrap), .done(done)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic stop_run();
    run = 1'b0;
    step();
    step();
  endtask

  task automatic write_entry(input int a, input logic [31:0] dr, input logic [31:0] pw,
                             input logic [31:0] df, input logic [31:0] pri);
    cfg_addr = a[3:0]; cfg_dr = dr; cfg_pw = pw; cfg_df = df; cfg_pri = pri;
    cfg_wr_en = 1'b1;
    m_dr[a] = dr; m_pw[a] = pw; m_df[a] = df; m_pri[a] = pri;
    step();
    cfg_wr_en = 1'b0;
  endtask

  function automatic logic [31:0] sat(input longint unsigned v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  // Expand the table into what the counter should see each cycle after run is taken.
  task automatic predict(input int ncyc, input int len);
    int le, idx, left;
    le   = (len == 0) ? 1 : ((len > 16) ? 16 : len);
    idx  = 0;
    left = int'(m_pri[0]) + 1;
    for (int c = 0; c < ncyc; c++) begin
      e_stb[c] = 1'b0;
      e_wrp[c] = 1'b0;
      if (left == 0) begin
        idx      = (idx + 1) % le;
        left     = int'(m_pri[idx]) + 1;
        e_stb[c] = 1'b1;
        e_wrp[c] = (idx == 0);
      end
      e_idx[c]  = 4'(idx);
      e_pri[c]  = m_pri[idx];
      e_dr[c]   = m_dr[idx];
      e_drpw[c] = sat(64'(m_dr[idx]) + 64'(m_pw[idx]));
      e_cov[c]  = sat(64'(m_df[idx]) + 64'(m_pw[idx]) + 64'(m_dr[idx]));
      left--;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({pri_o, dr_o, dr_pw_o, pw_cover_o} !== 128'h0 || ctr_nreset !== 1'b0 || cur_idx !== 4'h0 ||
        period_strobe !== 1'b0 || seq_wrap !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset got pri=%h dr=%h drpw=%h cov=%h ctr=%b idx=%0d stb=%b wrp=%b done=%b exp all zero",
               pri_o, dr_o, dr_pw_o, pw_cover_o, ctr_nreset, cur_idx, period_strobe, seq_wrap, done);
    end
  endtask

  task automatic test_basic();
    write_entry(0, 2, 3, 1, 9);
    write_entry(1, 1, 2, 0, 5);
    cfg_len = 5'd2;
    predict(40, 2);
    run = 1'b1;
    step();
    checks++;
    if (pri_o !== 32'd9 || dr_pw_o !== 32'd5 || pw_cover_o !== 32'd6 || ctr_nreset !== 1'b1) begin
      errors++;
      $display("FAIL basic_first got pri=%0d drpw=%0d cov=%0d ctr=%b exp pri=9 drpw=5 cov=6 ctr=1",
               pri_o, dr_pw_o, pw_cover_o, ctr_nreset);
    end
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (pri_o !== e_pri[c] || dr_o !== e_dr[c] || dr_pw_o !== e_drpw[c] || pw_cover_o !== e_cov[c] ||
          cur_idx !== e_idx[c] || period_strobe !== e_stb[c] || seq_wrap !== e_wrp[c] ||
          ctr_nreset !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic c=%0d got pri=%h dr=%h drpw=%h cov=%h idx=%0d stb=%b wrp=%b ctr=%b done=%b exp pri=%h dr=%h drpw=%h cov=%h idx=%0d stb=%b wrp=%b ctr=1 done=0",
                 c, pri_o, dr_o, dr_pw_o, pw_cover_o, cur_idx, period_strobe, seq_wrap, ctr_nreset, done,
                 e_pri[c], e_dr[c], e_drpw[c], e_cov[c], e_idx[c], e_stb[c], e_wrp[c]);
      end
      if (c == 10 || c == 16) begin
        checks++;
        if (period_strobe !== 1'b1 || cur_idx !== ((c == 10) ? 4'd1 : 4'd0) ||
            seq_wrap !== (c == 16) || dr_pw_o !== ((c == 10) ? 32'd3 : 32'd5)) begin
          errors++;
          $display("FAIL basic_boundary c=%0d got stb=%b idx=%0d wrp=%b drpw=%0d", c, period_strobe,
                   cur_idx, seq_wrap, dr_pw_o);
        end
      end
      step();
    end
    stop_run();
  endtask

  task automatic test_saturation();
    write_entry(0, 32'hFFFF_FFF0, 32'h20, 32'h10, 2);
    write_entry(1, 32'hFFFF_FFF0, 32'h0E, 32'h01, 1);
    cfg_len = 5'd2;
    predict(12, 2);
    run = 1'b1;
    step();
    checks++;
    if (dr_pw_o !== 32'hFFFF_FFFF || pw_cover_o !== 32'hFFFF_FFFF || dr_o !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL saturation got dr=%h drpw=%h cov=%h exp dr=fffffff0 drpw=ffffffff cov=ffffffff",
               dr_o, dr_pw_o, pw_cover_o);
    end
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (pri_o !== e_pri[c] || dr_o !== e_dr[c] || dr_pw_o !== e_drpw[c] || pw_cover_o !== e_cov[c] ||
          cur_idx !== e_idx[c] || period_strobe !== e_stb[c] || seq_wrap !== e_wrp[c]) begin
        errors++;
        $display("FAIL saturation c=%0d got pri=%h drpw=%h cov=%h idx=%0d stb=%b wrp=%b exp pri=%h drpw=%h cov=%h idx=%0d stb=%b wrp=%b",
                 c, pri_o, dr_pw_o, pw_cover_o, cur_idx, period_strobe, seq_wrap,
                 e_pri[c], e_drpw[c], e_cov[c], e_idx[c], e_stb[c], e_wrp[c]);
      end
      step();
    end
    stop_run();
  endtask

  task automatic test_pri_zero();
    write_entry(0, 10, 1, 0, 0);
    write_entry(1, 20, 1, 0, 0);
    write_entry(2, 30, 1, 0, 0);
    cfg_len = 5'd3;
    predict(13, 3);
    run = 1'b1;
    step();
    for (int c = 0; c < 13; c++) begin
      checks++;
      if (pri_o !== e_pri[c] || dr_o !== e_dr[c] || cur_idx !== e_idx[c] ||
          period_strobe !== e_stb[c] || seq_wrap !== e_wrp[c] || ctr_nreset !== 1'b1) begin
        errors++;
        $display("FAIL pri_zero c=%0d got dr=%0d idx=%0d stb=%b wrp=%b ctr=%b exp dr=%0d idx=%0d stb=%b wrp=%b ctr=1",
                 c, dr_o, cur_idx, period_strobe, seq_wrap, ctr_nreset, e_dr[c], e_idx[c], e_stb[c], e_wrp[c]);
      end
      step();
    end
    stop_run();
  endtask

  task automatic test_write_while_running();
    logic [31:0] want_pri;
    logic [3:0]  want_idx;
    write_entry(0, 1, 1, 1, 9);
    write_entry(1, 2, 2, 2, 3);
    cfg_len = 5'd2;
    run = 1'b1;
    step();
    for (int c = 0; c <= 36; c++) begin
      if (c == 10 || c == 18 || c == 28 || c == 36) begin
        want_pri = (c == 10 || c == 28) ? 32'd7 : ((c == 18) ? 32'd9 : 32'd2);
        want_idx = (c == 10 || c == 28) ? 4'd1 : 4'd0;
        checks++;
        if (pri_o !== want_pri || cur_idx !== want_idx || period_strobe !== 1'b1) begin
          errors++;
          $display("FAIL live_write c=%0d got pri=%0d idx=%0d stb=%b exp pri=%0d idx=%0d stb=1",
                   c, pri_o, cur_idx, period_strobe, want_pri, want_idx);
        end
      end
      cfg_wr_en = 1'b0;
      if (c == 4) begin
        cfg_addr = 4'd1; cfg_dr = 2; cfg_pw = 2; cfg_df = 2; cfg_pri = 7; cfg_wr_en = 1'b1;
        m_pri[1] = 7;
      end else if (c == 17) begin
        cfg_addr = 4'd0; cfg_dr = 1; cfg_pw = 1; cfg_df = 1; cfg_pri = 2; cfg_wr_en = 1'b1;
        m_pri[0] = 2;
      end
      step();
    end
    cfg_wr_en = 1'b0;
    stop_run();
  endtask

  task automatic test_run_drop_and_reset();
    write_entry(0, 4, 1, 0, 9);
    cfg_len = 5'd1;
    run = 1'b1;
    step();
    step(); step(); step();
    run = 1'b0;
    step();
    checks++;
    if (ctr_nreset !== 1'b0 || cur_idx !== 4'd0 || pri_o !== 32'd9 || dr_o !== 32'd4 || period_strobe !== 1'b0) begin
      errors++;
      $display("FAIL run_drop got ctr=%b idx=%0d pri=%0d dr=%0d stb=%b exp ctr=0 idx=0 pri=9 dr=4 stb=0",
               ctr_nreset, cur_idx, pri_o, dr_o, period_strobe);
    end
    run = 1'b1;
    step(); step();
    nreset = 1'b0;
    run = 1'b0;
    step();
    checks++;
    if ({pri_o, dr_o, dr_pw_o, pw_cover_o} !== 128'h0 || ctr_nreset !== 1'b0 || cur_idx !== 4'd0 ||
        period_strobe !== 1'b0 || seq_wrap !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got pri=%h dr=%h drpw=%h cov=%h ctr=%b idx=%0d exp all zero",
               pri_o, dr_o, dr_pw_o, pw_cover_o, ctr_nreset, cur_idx);
    end
    for (int i = 0; i < 16; i++) begin m_dr[i] = 0; m_pw[i] = 0; m_df[i] = 0; m_pri[i] = 0; end
    nreset = 1'b1;
    run = 1'b1;
    step();
    step();
    checks++;
    if (pri_o !== 32'd0 || dr_o !== 32'd0 || dr_pw_o !== 32'd0 || pw_cover_o !== 32'd0 ||
        ctr_nreset !== 1'b1 || period_strobe !== 1'b1) begin
      errors++;
      $display("FAIL table_cleared got pri=%h dr=%h drpw=%h cov=%h ctr=%b stb=%b exp zeros ctr=1 stb=1",
               pri_o, dr_o, dr_pw_o, pw_cover_o, ctr_nreset, period_strobe);
    end
    stop_run();
  endtask

  task automatic test_random();
    int lens[4];
    lens[0] = 0;
    lens[1] = 20;
    lens[2] = $urandom_range(2, 16);
    lens[3] = $urandom_range(1, 31);
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) begin
        write_entry(i, ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom,
                    ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom,
                    $urandom, 32'($urandom_range(0, 5)));
      end
      cfg_len = 5'(lens[t]);
      predict(60, lens[t]);
      run = 1'b1;
      step();
      for (int c = 0; c < 60; c++) begin
        checks++;
        if (pri_o !== e_pri[c] || dr_o !== e_dr[c] || dr_pw_o !== e_drpw[c] || pw_cover_o !== e_cov[c] ||
            cur_idx !== e_idx[c] || period_strobe !== e_stb[c] || seq_wrap !== e_wrp[c] || ctr_nreset !== 1'b1) begin
          errors++;
          $display("FAIL random t=%0d len=%0d c=%0d got pri=%h dr=%h drpw=%h cov=%h idx=%0d stb=%b wrp=%b ctr=%b exp pri=%h dr=%h drpw=%h cov=%h idx=%0d stb=%b wrp=%b ctr=1",
                   t, lens[t], c, pri_o, dr_o, dr_pw_o, pw_cover_o, cur_idx, period_strobe, seq_wrap, ctr_nreset,
                   e_pri[c], e_dr[c], e_drpw[c], e_cov[c], e_idx[c], e_stb[c], e_wrp[c]);
        end
        step();
      end
      stop_run();
    end
  endtask

`ifdef SEQ_BURST_EN
  task automatic test_burst();
    write_entry(0, 1, 1, 1, 3);
    write_entry(1, 2, 2, 2, 3);
    cfg_len = 5'd2;
    cfg_bursts = 16'd2;
    run = 1'b1;
    step();
    cfg_bursts = 16'd0;
    for (int c = 0; c <= 17; c++) begin
      checks++;
      if (done !== (c >= 16) || ctr_nreset !== (c < 16)) begin
        errors++;
        $display("FAIL burst c=%0d got done=%b ctr=%b exp done=%b ctr=%b", c, done, ctr_nreset, c >= 16, c < 16);
      end
      step();
    end
    run = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || ctr_nreset !== 1'b0) begin
      errors++;
      $display("FAIL burst_release got done=%b ctr=%b exp done=0 ctr=0", done, ctr_nreset);
    end
    step();
  endtask
`endif

  initial begin
    nreset = 1'b0; run = 1'b0; cfg_wr_en = 1'b0; cfg_addr = '0;
    cfg_dr = '0; cfg_pw = '0; cfg_df = '0; cfg_pri = '0; cfg_len = 5'd1;
`ifdef SEQ_BURST_EN
    cfg_bursts = '0;
`endif
    for (int i = 0; i < 16; i++) begin m_dr[i] = 0; m_pw[i] = 0; m_df[i] = 0; m_pri[i] = 0; end
    step();
    step();
    test_reset();
    nreset = 1'b1;
    step();
    test_basic();
    test_saturation();
    test_pri_zero();
    test_write_while_running();
    test_run_drop_and_reset();
    test_random();
`ifdef SEQ_BURST_EN
    test_burst();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
